// File: rtl/bist_sram_responder.sv
// bist_sram_responder: word SRAM model with lane masks, injectable stuck-at/coupling faults and access bookkeeping
module bist_sram_responder #(
  parameter int MAX_ADDR   = 255,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int ADDR_WIDTH = $clog2(MAX_ADDR + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic                          re,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic [MASK_WIDTH-1:0]         wmask,
  output logic [DATA_WIDTH-1:0]         dout,
  input  logic                          fault_load,
  input  logic [1:0]                    fault_type,
  input  logic [ADDR_WIDTH-1:0]         fault_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] fault_bit,
  input  logic [ADDR_WIDTH-1:0]         fault_aggr,
  output logic [15:0]                   wr_count,
  output logic [15:0]                   rd_count,
  output logic                          addr_err,
  output logic                          proto_err
);
  localparam int LW = DATA_WIDTH / MASK_WIDTH;
  localparam int BW = $clog2(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] mem [0:MAX_ADDR];
  logic [1:0]            f_type;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [ADDR_WIDTH-1:0] f_aggr;
  logic [BW-1:0]         f_bit;
  logic                  in_range;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  couple;
  logic [DATA_WIDTH-1:0] bit_en;
  logic [DATA_WIDTH-1:0] rd_word;
  // When the address port cannot express an out-of-range word, every address is valid.
  generate
    if (MAX_ADDR >= 2 ** ADDR_WIDTH - 1) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = addr <= ADDR_WIDTH'(MAX_ADDR);
    end
  endgenerate
  genvar i;
  generate
    for (i = 0; i < MASK_WIDTH; i++) begin : g_lane
      assign bit_en[i*LW +: LW] = {LW{wmask[i]}};
    end
  endgenerate
  assign wr_ok  = !rst && we && in_range;
  assign rd_ok  = !rst && re && !we && in_range;
  assign couple = wr_ok && f_type == 2'd3 && addr == f_aggr && f_aggr != f_addr && bit_en[f_bit];
  // Stuck-at faults only distort the read path; type 1 forces 0, type 2 forces 1.
  always_comb begin
    rd_word = mem[addr];
    rd_word[f_bit] = (addr == f_addr && (f_type[1] ^ f_type[0])) ? f_type[1] : rd_word[f_bit];
  end
  // Storage survives reset; a coupling hit flips the victim bit on the aggressor's write edge.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[addr] <= (mem[addr] & ~bit_en) | (data & bit_en);
    if (couple) mem[f_addr][f_bit] <= ~mem[f_addr][f_bit];
  end
  // Read data, saturating counters, sticky error flags and the fault configuration register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      addr_err  <= 1'b0;
      proto_err <= 1'b0;
      f_type    <= 2'd0;
      f_addr    <= '0;
      f_aggr    <= '0;
      f_bit     <= '0;
    end else begin
      dout      <= rd_ok ? rd_word : (re && !we && !in_range) ? '0 : dout;
      wr_count  <= wr_count + {15'd0, wr_ok && ~&wr_count};
      rd_count  <= rd_count + {15'd0, rd_ok && ~&rd_count};
      addr_err  <= addr_err | ((we | re) & !in_range);
      proto_err <= proto_err | (we & re);
      f_type    <= fault_load ? fault_type : f_type;
      f_addr    <= fault_load ? fault_addr : f_addr;
      f_aggr    <= fault_load ? fault_aggr : f_aggr;
      f_bit     <= fault_load ? fault_bit : f_bit;
    end
  end
endmodule

// File: tb/tb_bist_sram_responder.sv
// tb_bist_sram_responder: directed and random stimulus against a behavioural SRAM/fault model with a per-cycle scoreboard
module tb_bist_sram_responder;
  localparam int MA = 200;
  logic        clk = 0, rst = 1, we = 0, re = 0, fault_load = 0;
  logic [7:0]  addr = 0, fault_addr = 0, fault_aggr = 0;
  logic [31:0] data = 0, dout;
  logic [3:0]  wmask = 0;
  logic [1:0]  fault_type = 0;
  logic [4:0]  fault_bit = 0;
  logic [15:0] wr_count, rd_count;
  logic        addr_err, proto_err;
  always #5 clk = ~clk;
  bist_sram_responder #(.MAX_ADDR(MA), .DATA_WIDTH(32), .MASK_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data(data), .wmask(wmask), .dout(dout),
    .fault_load(fault_load), .fault_type(fault_type), .fault_addr(fault_addr), .fault_bit(fault_bit),
    .fault_aggr(fault_aggr), .wr_count(wr_count), .rd_count(rd_count), .addr_err(addr_err), .proto_err(proto_err)
  );
  typedef struct packed {
    logic [31:0] dout;
    logic [15:0] wc;
    logic [15:0] rc;
    logic        ae;
    logic        pe;
  } exp_t;
  exp_t        q[$];
  exp_t        m = '0;
  logic [31:0] mm [0:MA];
  int          mt = 0, ma = 0, mb = 0, mg = 0;
  int          checks = 0, errors = 0;
  // Model one clock edge from the spec rules, then record the expected outputs after that edge.
  task automatic cyc(input logic r, input logic w, input logic rd, input int a, input logic [31:0] d, input logic [3:0] k);
    logic [31:0] bits, v;
    bit ok;
    rst = r; we = w; re = rd; addr = a[7:0]; data = d; wmask = k;
    ok = a <= MA;
    if (r) begin
      m = '0; mt = 0; ma = 0; mb = 0; mg = 0;
    end else begin
      if (w && ok) begin
        bits = 0;
        for (int i = 0; i < 4; i++) if (k[i]) bits[i*8 +: 8] = 8'hFF;
        mm[a] = (mm[a] & ~bits) | (d & bits);
        if (mt == 3 && a == mg && mg != ma && bits[mb]) mm[ma][mb] = ~mm[ma][mb];
        if (m.wc != 16'hFFFF) m.wc = m.wc + 16'd1;
      end
      if (rd && !w && ok) begin
        v = mm[a];
        if (a == ma && mt == 1) v[mb] = 1'b0;
        if (a == ma && mt == 2) v[mb] = 1'b1;
        m.dout = v;
        if (m.rc != 16'hFFFF) m.rc = m.rc + 16'd1;
      end
      if (rd && !w && !ok) m.dout = 0;
      if ((w || rd) && !ok) m.ae = 1'b1;
      if (w && rd) m.pe = 1'b1;
      if (fault_load) begin
        mt = fault_type; ma = fault_addr; mb = fault_bit; mg = fault_aggr;
      end
    end
    @(posedge clk);
    q.push_back(m);
    #1;
  endtask
  task automatic load_fault(input logic [1:0] t, input int va, input int b, input int ga);
    fault_type = t; fault_addr = va[7:0]; fault_bit = b[4:0]; fault_aggr = ga[7:0]; fault_load = 1;
    cyc(0, 0, 0, 0, 0, 0);
    fault_load = 0;
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  // Scoreboard monitor: every clock edge leaves one expected output record to compare.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({dout, wr_count, rd_count, addr_err, proto_err} !== e) begin
        errors++;
        $display("FAIL outputs: got dout=%h wr=%0d rd=%0d ae=%b pe=%b expected dout=%h wr=%0d rd=%0d ae=%b pe=%b",
                 dout, wr_count, rd_count, addr_err, proto_err, e.dout, e.wc, e.rc, e.ae, e.pe);
      end
    end
  end
  initial begin
    int a, w, rd;
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    chk("reset_dout", dout, 0);
    cyc(0, 1, 0, 5, 32'hDEADBEEF, 4'hF);
    cyc(0, 0, 1, 5, 0, 0);
    chk("basic_read", dout, 32'hDEADBEEF);
    chk("basic_wr_count", 32'(wr_count), 1);
    chk("basic_rd_count", 32'(rd_count), 1);
    cyc(0, 1, 0, 7, 0, 4'hF);
    cyc(0, 1, 0, 7, 32'hFFFFFFFF, 4'b0101);
    cyc(0, 0, 1, 7, 0, 0);
    chk("lane_mask", dout, 32'h00FF00FF);
    load_fault(2, 3, 0, 0);
    cyc(0, 1, 0, 3, 0, 4'hF);
    cyc(0, 0, 1, 3, 0, 0);
    chk("stuck_at_1", dout, 32'h00000001);
    load_fault(0, 0, 0, 0);
    cyc(0, 0, 1, 3, 0, 0);
    chk("fault_cleared", dout, 32'h00000000);
    load_fault(3, 11, 31, 10);
    cyc(0, 1, 0, 11, 0, 4'hF);
    cyc(0, 1, 0, 10, 0, 4'h8);
    cyc(0, 0, 1, 11, 0, 0);
    chk("coupling_flip", dout, 32'h80000000);
    cyc(0, 1, 0, 10, 0, 4'h1);
    cyc(0, 0, 1, 11, 0, 0);
    chk("coupling_lane_off", dout, 32'h80000000);
    load_fault(3, 12, 0, 12);
    cyc(0, 1, 0, 12, 0, 4'hF);
    cyc(0, 0, 1, 12, 0, 0);
    chk("coupling_self", dout, 32'h00000000);
    load_fault(0, 0, 0, 0);
    cyc(0, 1, 0, 2, 32'hCAFEF00D, 4'hF);
    cyc(0, 0, 1, 2, 0, 0);
    cyc(0, 1, 1, 2, 32'h12345678, 4'hF);
    chk("proto_err", 32'(proto_err), 1);
    chk("proto_dout_hold", dout, 32'hCAFEF00D);
    cyc(0, 0, 1, 2, 0, 0);
    chk("proto_write_done", dout, 32'h12345678);
    cyc(0, 0, 1, MA + 1, 0, 0);
    chk("oob_dout", dout, 0);
    chk("oob_addr_err", 32'(addr_err), 1);
    cyc(0, 1, 0, 4, 32'hAAAA5555, 4'hF);
    cyc(1, 1, 0, 4, 32'h0BADF00D, 4'hF);
    chk("rst_outputs", {dout[15:0], wr_count}, 0);
    cyc(0, 0, 1, 4, 0, 0);
    chk("rst_no_write", dout, 32'hAAAA5555);
    for (int i = 0; i <= MA; i++) cyc(0, 1, 0, i, $urandom, 4'hF);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        fault_type = 2'($urandom_range(0, 3)); fault_addr = 8'($urandom_range(0, 15));
        fault_aggr = 8'($urandom_range(0, 15)); fault_bit = 5'($urandom_range(0, 31)); fault_load = 1;
      end
      w = $urandom_range(0, 1); rd = $urandom_range(0, 1);
      a = $urandom_range(0, 7) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 15);
      if (w && rd && a > MA) a = a % 16;
      cyc($urandom_range(0, 299) == 0, w[0], rd[0], a, $urandom, 4'($urandom));
      fault_load = 0;
    end
    for (int n = 0; n < 65540; n++) cyc(0, 1, 0, $urandom_range(0, MA), $urandom, 4'($urandom));
    chk("wr_saturate", 32'(wr_count), 32'hFFFF);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bist_sram_responder.md
BIST_SRAM_RESPONDER -- requirements
Module: bist_sram_responder

Interface
REQ-001 Parameter MAX_ADDR, default 255, highest valid word address.
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 Parameter MASK_WIDTH, default 4, write-mask lanes; DATA_WIDTH SHALL be a multiple of MASK_WIDTH; lane width LW = DATA_WIDTH/MASK_WIDTH.
REQ-004 Parameter ADDR_WIDTH, default $clog2(MAX_ADDR+1), address port width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 we  input  1  write strobe.
REQ-008 re  input  1  read strobe.
REQ-009 addr  input  ADDR_WIDTH  word address.
REQ-010 data  input  DATA_WIDTH  write data.
REQ-011 wmask  input  MASK_WIDTH  per-lane write enable; bit i covers data[i*LW +: LW].
REQ-012 dout  output  DATA_WIDTH  registered read data.
REQ-013 fault_load  input  1  one-cycle strobe capturing fault_type/fault_addr/fault_bit/fault_aggr.
REQ-014 fault_type  input  2  0 none, 1 stuck-at-0, 2 stuck-at-1, 3 coupling.
REQ-015 fault_addr  input  ADDR_WIDTH  victim word address.
REQ-016 fault_bit  input  $clog2(DATA_WIDTH)  victim bit index.
REQ-017 fault_aggr  input  ADDR_WIDTH  aggressor word address (coupling only).
REQ-018 wr_count, rd_count  output  16 each  accepted write/read counts, saturating at 16'hFFFF.
REQ-019 addr_err  output  1  sticky: access with addr > MAX_ADDR seen.
REQ-020 proto_err  output  1  sticky: we and re asserted in same cycle seen.

Function
REQ-021 Storage SHALL be MAX_ADDR+1 words of DATA_WIDTH; contents undefined after power-up and SHALL NOT be cleared by rst.
REQ-022 Write (we=1, addr<=MAX_ADDR): lanes with wmask[i]=1 updated at the edge; other lanes unchanged; wmask=0 writes nothing but still counts.
REQ-023 Read (re=1, we=0, addr<=MAX_ADDR): dout SHALL show the stored word (after fault effects) exactly one cycle after the re cycle; dout SHALL hold its value in all cycles without an accepted read.
REQ-024 Read of an address written in the immediately preceding cycle SHALL return the newly written data.
REQ-025 we=1 and re=1 together: write performed, read ignored (dout holds, rd_count unchanged), proto_err set.
REQ-026 addr > MAX_ADDR with we or re: storage unchanged, dout loaded with 0 if re, counters unchanged, addr_err set.
REQ-027 Fault config SHALL be registered on fault_load; new config effective from the next cycle; fault_load concurrent with an access applies the old config to that access.
REQ-028 Stuck-at-0/1: every read of fault_addr SHALL return bit fault_bit forced to 0/1; stored value unaffected.
REQ-029 Coupling: an accepted write to fault_aggr whose lane containing fault_bit is enabled SHALL invert stored bit fault_bit of fault_addr in the same edge; if fault_aggr == fault_addr the write value takes effect and no inversion occurs.
REQ-030 fault_type 0 SHALL leave all accesses fault-free.
REQ-031 Counters increment by 1 per accepted access and SHALL NOT wrap.
REQ-032 Sticky flags cleared only by rst.

Reset
REQ-033 While rst=1: dout=0, wr_count=0, rd_count=0, addr_err=0, proto_err=0, fault config = type 0; accesses in a rst cycle SHALL be ignored (no storage change).
REQ-034 First access accepted in the first cycle with rst=0.

Verification
REQ-035 Write 0xDEADBEEF to addr 5 wmask 4'hF, then re addr 5 -> dout=0xDEADBEEF the following cycle, wr_count=1, rd_count=1.
REQ-036 Addr 7 holds 0x00000000; write 0xFFFFFFFF wmask 4'b0101, read -> dout=0x00FF00FF.
REQ-037 Load stuck-at-1 addr 3 bit 0; write 0 to addr 3, read -> dout=0x00000001; load type 0, read -> dout=0x00000000.
REQ-038 Load coupling aggr 10, victim 11 bit 31; addr 11 holds 0; write 0x0 wmask 4'h8 to addr 10 -> read 11 gives 0x80000000; wmask 4'h1 write -> no inversion.
REQ-039 we=re=1 at addr 2 with data 0x12345678 -> proto_err=1, dout unchanged, subsequent read addr 2 -> 0x12345678; re at addr MAX_ADDR+1 -> dout=0, addr_err=1.
REQ-040 rst asserted concurrent with write to addr 4 -> addr 4 unchanged, all outputs zero; 65536 writes -> wr_count stays 16'hFFFF.
